// File: rtl/switch_allocator_if.sv
// Route-reservation and flit-crossbar bundle between the input ports, the
// switch allocator and the downstream output channels.
interface switch_allocator_if #(
  parameter int unsigned N             = 4,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned REQUEST_WIDTH = 2
);
  logic [N-1:0]               routeReserveRequestValid;
  logic [N*REQUEST_WIDTH-1:0] routeReserveRequest;
  logic [N-1:0]               routeRelieve;
  logic [N-1:0]               routeReserveStatus;
  logic [N*DATA_WIDTH-1:0]    in_data;
  logic [N-1:0]               in_valid;
  logic [N-1:0]               in_ready;
  logic [N*DATA_WIDTH-1:0]    out_data;
  logic [N-1:0]               out_valid;
  logic [N-1:0]               out_ready;

  // Environment side: input ports plus downstream output channels.
  modport master (
    output routeReserveRequestValid, routeReserveRequest, routeRelieve,
    output in_data, in_valid, out_ready,
    input  routeReserveStatus, in_ready, out_data, out_valid
  );

  // Allocator side.
  modport slave (
    input  routeReserveRequestValid, routeReserveRequest, routeRelieve,
    input  in_data, in_valid, out_ready,
    output routeReserveStatus, in_ready, out_data, out_valid
  );
endinterface

// File: rtl/switch_allocator.sv
// Switch allocator: per-output round-robin grant of output channels to input
// ports, held until relieved, plus the combinational flit crossbar.
module switch_allocator #(
  parameter int unsigned N             = 4,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned REQUEST_WIDTH = 2
) (
  input logic           clk,
  input logic           rst,
  switch_allocator_if.slave bus
);
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned RW = REQUEST_WIDTH;
  localparam int unsigned DW = DATA_WIDTH;

  logic [N-1:0]  owner_valid_q, owner_valid_d;
  logic [N-1:0]  granted_q, granted_d;
  logic [RW-1:0] owner_q  [N];
  logic [RW-1:0] owner_d  [N];
  logic [RW-1:0] rr_ptr_q [N];
  logic [RW-1:0] rr_ptr_d [N];
  logic [RW-1:0] dest_q   [N];
  logic [RW-1:0] dest_d   [N];
  logic [RW-1:0] req_idx  [N];
  logic [N-1:0]  eligible [N];

  // eligible[o][i]: port i may win output o this edge.
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      req_idx[i] = bus.routeReserveRequest[i*RW +: RW];
    end
    for (int unsigned o = 0; o < N; o++) begin
      for (int unsigned i = 0; i < N; i++) begin
        eligible[o][i] = bus.routeReserveRequestValid[i] && (req_idx[i] == RW'(o)) &&
                         !granted_q[i] && !bus.routeRelieve[i];
      end
    end
  end

  // Relieve frees the owned output; arbitration only looks at outputs free
  // at the start of the cycle, so a freed output waits one edge.
  always_comb begin
    int unsigned cand;
    logic        found;
    cand          = '0;
    found         = 1'b0;
    owner_valid_d = owner_valid_q;
    granted_d     = granted_q;
    for (int unsigned k = 0; k < N; k++) begin
      owner_d[k]  = owner_q[k];
      rr_ptr_d[k] = rr_ptr_q[k];
      dest_d[k]   = dest_q[k];
    end

    for (int unsigned i = 0; i < N; i++) begin
      if (bus.routeRelieve[i] && granted_q[i]) begin
        granted_d[i]                   = 1'b0;
        owner_valid_d[IW'(dest_q[i])] = 1'b0;
      end
    end

    for (int unsigned o = 0; o < N; o++) begin
      found = 1'b0;
      if (!owner_valid_q[o]) begin
        for (int unsigned k = 0; k < N; k++) begin
          cand = (32'(rr_ptr_q[o]) + k) % N;
          if (!found && eligible[o][IW'(cand)]) begin
            found                 = 1'b1;
            owner_d[o]            = RW'(cand);
            owner_valid_d[o]      = 1'b1;
            granted_d[IW'(cand)]  = 1'b1;
            dest_d[IW'(cand)]     = RW'(o);
            rr_ptr_d[o]           = RW'((cand + 1) % N);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      owner_valid_q <= '0;
      granted_q     <= '0;
      for (int unsigned k = 0; k < N; k++) begin
        owner_q[k]  <= '0;
        rr_ptr_q[k] <= '0;
        dest_q[k]   <= '0;
      end
    end else begin
      owner_valid_q <= owner_valid_d;
      granted_q     <= granted_d;
      for (int unsigned k = 0; k < N; k++) begin
        owner_q[k]  <= owner_d[k];
        rr_ptr_q[k] <= rr_ptr_d[k];
        dest_q[k]   <= dest_d[k];
      end
    end
  end

  assign bus.routeReserveStatus = granted_q;

  // Zero-latency crossbar in both directions.
  always_comb begin
    bus.out_data  = '0;
    bus.out_valid = '0;
    bus.in_ready  = '0;
    for (int unsigned o = 0; o < N; o++) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (owner_valid_q[o] && (owner_q[o] == RW'(i))) begin
          bus.out_data[o*DW +: DW] = bus.in_data[i*DW +: DW];
          bus.out_valid[o]         = bus.in_valid[i];
        end
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      for (int unsigned o = 0; o < N; o++) begin
        if (granted_q[i] && (dest_q[i] == RW'(o))) begin
          bus.in_ready[i] = bus.out_ready[o];
        end
      end
    end
  end
endmodule

// File: tb/tb_switch_allocator.sv
// Directed bench for switch_allocator: a rule-level grant model checked every
// cycle, plus hand-computed expectations for each scenario.
module tb_switch_allocator;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int RW = 3;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  bit   started = 0;

  int m_ov[N], m_own[N], m_rr[N], m_gr[N], m_dest[N];
  logic [7:0] rx3[$];

  switch_allocator_if #(.N(N), .DATA_WIDTH(DW), .REQUEST_WIDTH(RW)) ifc ();

  switch_allocator #(.N(N), .DATA_WIDTH(DW), .REQUEST_WIDTH(RW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic set_req(input int p, input int idx, input bit v);
    ifc.routeReserveRequestValid[p] = v;
    ifc.routeReserveRequest[p*RW +: RW] = RW'(idx);
  endtask

  // Model: relieve frees owned outputs; outputs free at cycle start grant the
  // first eligible port scanning from their round-robin pointer.
  always @(posedge clk) begin : model
    int gr0[N];
    int fr[N];
    int p;
    int r;
    started = 1;
    if (!rst) begin
      for (int k = 0; k < N; k++) begin
        m_ov[k] = 0; m_own[k] = 0; m_rr[k] = 0; m_gr[k] = 0; m_dest[k] = 0;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        gr0[k] = m_gr[k];
        fr[k]  = (m_ov[k] == 0) ? 1 : 0;
      end
      for (int i = 0; i < N; i++)
        if (ifc.routeRelieve[i] && gr0[i] != 0) begin
          m_gr[i] = 0;
          m_ov[m_dest[i]] = 0;
        end
      for (int o = 0; o < N; o++) begin
        if (fr[o] != 0) begin
          for (int k = 0; k < N; k++) begin
            p = (m_rr[o] + k) % N;
            r = int'(ifc.routeReserveRequest[p*RW +: RW]);
            if (ifc.routeReserveRequestValid[p] && r == o && gr0[p] == 0 && !ifc.routeRelieve[p]) begin
              m_ov[o] = 1; m_own[o] = p; m_gr[p] = 1; m_dest[p] = o;
              m_rr[o] = (p + 1) % N;
              break;
            end
          end
        end
      end
    end
  end

  // Per-cycle compare against the model, and collection of flits leaving output 3.
  always @(negedge clk) begin : compare
    logic [N-1:0]    e_st, e_rdy, e_ov;
    logic [N*DW-1:0] e_od;
    if (started) begin
      e_st = '0; e_rdy = '0; e_ov = '0; e_od = '0;
      for (int i = 0; i < N; i++) begin
        e_st[i]  = (m_gr[i] != 0);
        e_rdy[i] = (m_gr[i] != 0) && ifc.out_ready[m_dest[i]];
      end
      for (int o = 0; o < N; o++)
        if (m_ov[o] != 0) begin
          e_ov[o] = ifc.in_valid[m_own[o]];
          e_od[o*DW +: DW] = ifc.in_data[m_own[o]*DW +: DW];
        end
      chk("model_status", 32'(ifc.routeReserveStatus), 32'(e_st));
      chk("model_in_ready", 32'(ifc.in_ready), 32'(e_rdy));
      chk("model_out_valid", 32'(ifc.out_valid), 32'(e_ov));
      chk("model_out_data", ifc.out_data, e_od);
      if (rst && ifc.out_valid[3] && ifc.out_ready[3]) rx3.push_back(ifc.out_data[31:24]);
    end
  end

  initial begin
    int k;
    bit pat[10];
    pat = '{1, 0, 0, 0, 1, 1, 1, 1, 1, 1};

    // Reset with random inputs.
    rst = 1'b0;
    ifc.routeReserveRequestValid = 4'($urandom);
    ifc.routeReserveRequest      = 12'($urandom);
    ifc.routeRelieve             = 4'($urandom);
    ifc.in_data                  = $urandom;
    ifc.in_valid                 = 4'($urandom);
    ifc.out_ready                = 4'($urandom);
    tick(); tick();
    mid();
    chk("reset_status", 32'(ifc.routeReserveStatus), 0);
    chk("reset_in_ready", 32'(ifc.in_ready), 0);
    chk("reset_out_valid", 32'(ifc.out_valid), 0);
    chk("reset_out_data", ifc.out_data, 0);
    tick();
    rst = 1'b1;
    ifc.routeReserveRequestValid = '0;
    ifc.routeReserveRequest      = '0;
    ifc.routeRelieve             = '0;
    ifc.in_data                  = '0;
    ifc.in_valid                 = '0;
    ifc.out_ready                = '1;
    rx3.delete();

    // Single path 1 -> 3, flits in the grant cycle onward.
    set_req(1, 3, 1);
    tick();
    set_req(1, 3, 0);
    ifc.in_valid[1] = 1'b1;
    for (int f = 0; f < 6; f++) begin
      ifc.in_data[15:8] = 8'hA1 + 8'(f);
      mid();
      if (f == 0) chk("grant_p1", 32'(ifc.routeReserveStatus), 32'h2);
      chk("path_data", 32'(ifc.out_data[31:24]), 32'(8'hA1 + 8'(f)));
      chk("path_valid", 32'(ifc.out_valid[3]), 1);
      tick();
    end
    ifc.in_valid[1] = 1'b0;
    ifc.routeRelieve[1] = 1'b1;
    tick();
    ifc.routeRelieve[1] = 1'b0;
    mid();
    chk("relieve_p1", 32'(ifc.routeReserveStatus), 0);
    chk("path_rx_count", rx3.size(), 6);
    for (int f = 0; f < 6 && f < rx3.size(); f++) chk("path_rx_flit", 32'(rx3[f]), 32'(8'hA1 + 8'(f)));
    rx3.delete();

    // Contention on output 1.
    tick();
    set_req(0, 1, 1); set_req(2, 1, 1);
    tick();
    mid();
    chk("cont_first_p0", 32'(ifc.routeReserveStatus), 32'h1);
    tick();
    set_req(0, 1, 0);
    ifc.routeRelieve[0] = 1'b1;
    tick();
    ifc.routeRelieve[0] = 1'b0;
    mid();
    chk("freed_not_regranted", 32'(ifc.routeReserveStatus), 0);
    tick();
    mid();
    chk("cont_next_p2", 32'(ifc.routeReserveStatus), 32'h4);
    tick();
    set_req(2, 1, 0);
    ifc.routeRelieve[2] = 1'b1;
    tick();
    ifc.routeRelieve[2] = 1'b0;
    set_req(0, 1, 1); set_req(2, 1, 1);
    tick();
    mid();
    chk("cont_wrap_p0", 32'(ifc.routeReserveStatus), 32'h1);
    tick();
    set_req(0, 1, 0); set_req(2, 1, 0);
    ifc.routeRelieve[0] = 1'b1;
    tick();
    ifc.routeRelieve[0] = 1'b0;
    mid();
    chk("cont_clear", 32'(ifc.routeReserveStatus), 0);

    // Four parallel grants, distinct flits on every path.
    tick();
    set_req(0, 1, 1); set_req(1, 0, 1); set_req(2, 3, 1); set_req(3, 2, 1);
    tick();
    ifc.routeReserveRequestValid = '0;
    ifc.in_valid = 4'hF;
    ifc.in_data  = 32'h43322110;
    mid();
    chk("par_status", 32'(ifc.routeReserveStatus), 32'hF);
    chk("par_out_data", ifc.out_data, 32'h32431021);
    chk("par_out_valid", 32'(ifc.out_valid), 32'hF);
    chk("par_in_ready", 32'(ifc.in_ready), 32'hF);
    tick();
    ifc.in_valid = '0;
    ifc.routeRelieve = 4'hF;
    tick();
    ifc.routeRelieve = '0;
    mid();
    chk("par_clear", 32'(ifc.routeReserveStatus), 0);
    rx3.delete();

    // Backpressure on 1 -> 3.
    tick();
    set_req(1, 3, 1);
    tick();
    set_req(1, 3, 0);
    k = 0;
    for (int c = 0; c < 10; c++) begin
      ifc.out_ready[3] = pat[c];
      ifc.in_valid[1]  = (k < 5);
      ifc.in_data[15:8] = 8'hB1 + 8'(k);
      mid();
      if (!pat[c]) begin
        chk("bp_in_ready", 32'(ifc.in_ready[1]), 0);
        chk("bp_out_valid", 32'(ifc.out_valid[3]), 1);
        chk("bp_out_data", 32'(ifc.out_data[31:24]), 32'(8'hB1 + 8'(k)));
      end
      tick();
      if (pat[c] && k < 5) k++;
    end
    ifc.in_valid[1] = 1'b0;
    ifc.out_ready = '1;
    chk("bp_rx_count", rx3.size(), 5);
    for (int f = 0; f < 5 && f < rx3.size(); f++) chk("bp_rx_flit", 32'(rx3[f]), 32'(8'hB1 + 8'(f)));

    // Illegal index, spurious relieve, second request from a granted port.
    set_req(0, 5, 1); set_req(1, 0, 1);
    ifc.routeRelieve[2] = 1'b1;
    ifc.in_valid[1] = 1'b1;
    ifc.in_data[15:8] = 8'hC7;
    for (int c = 0; c < 3; c++) begin
      tick();
      ifc.routeRelieve[2] = 1'b0;
      mid();
      chk("illegal_idx_status", 32'(ifc.routeReserveStatus), 32'h2);
      chk("regrant_ignored", 32'(ifc.out_valid[0]), 0);
    end
    tick();
    set_req(0, 5, 0); set_req(1, 0, 0); set_req(3, 0, 1);
    ifc.in_valid[3] = 1'b1;
    ifc.in_data[31:24] = 8'h5E;
    tick();
    set_req(3, 0, 0);
    mid();
    chk("out0_to_p3", 32'(ifc.routeReserveStatus), 32'hA);
    chk("out0_data", 32'(ifc.out_data[7:0]), 32'h5E);
    tick();
    ifc.in_valid = '0;
    ifc.routeRelieve = 4'hA;
    tick();
    ifc.routeRelieve = '0;
    tick();
    mid();
    chk("final_clear", 32'(ifc.routeReserveStatus), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
